// File: rtl/sram22_ctrl_pkg.sv
// Shared defaults, request struct and sizing helper for the sram22 port controller.
package sram22_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_WMASK_WIDTH = 1;
  localparam int DEF_RSP_DEPTH   = 3;

  typedef struct packed {
    logic                       we;
    logic [DEF_WMASK_WIDTH-1:0] wmask;
    logic [DEF_ADDR_WIDTH-1:0]  addr;
    logic [DEF_DATA_WIDTH-1:0]  wdata;
  } req_t;

  // Occupancy counter must hold the values 0..depth inclusive.
  function automatic int rsp_cnt_width(input int depth);
    if (depth < 1) begin
      return 1;
    end else begin
      return $clog2(depth + 1);
    end
  endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// In-order read-response buffer: DEPTH entries, occupancy count, head entry exposed.
module sram22_rsp_fifo
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_RSP_DEPTH,
  parameter int CW         = rsp_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign pop_s = pop && (count_r != {CW{1'b0}});

  // Storage, pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/sram22_port_ctrl.sv
// Requester-side controller for one sram22 macro: credit-based request channel,
// one-cycle read capture and a buffered in-order response channel.
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
  parameter int RSP_DEPTH   = DEF_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output logic                   idle
);

  localparam int CW = rsp_cnt_width(RSP_DEPTH);
  localparam int OW = CW + 1;

  logic [CW-1:0] fifo_count_s;
  logic [OW-1:0] occupancy_s;
  logic          req_fire_s;
  logic          read_fire_s;
  logic          read_pend_r;
  logic          rsp_pop_s;

  // A pending read already owns a buffer slot, so it counts against credit.
  assign occupancy_s = OW'(fifo_count_s) + OW'(read_pend_r);

  // Credit check depends only on registered state and rst.
  always_comb begin
    req_ready = 1'b0;
    if (rst) begin
      req_ready = 1'b0;
    end else begin
      req_ready = (occupancy_s < OW'(RSP_DEPTH));
    end
  end

  assign req_fire_s  = req_valid && req_ready;
  assign read_fire_s = req_fire_s && !req_we;

  // Idle cycles present a read to the macro whose data is never captured.
  assign sram_we    = req_fire_s && req_we;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  // Marks that sram_dout holds read data to be captured at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_pend_r <= 1'b0;
    end else begin
      read_pend_r <= read_fire_s;
    end
  end

  assign rsp_pop_s = rsp_valid && rsp_ready;

  sram22_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH),
    .CW         (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (read_pend_r),
    .push_data (sram_dout),
    .pop       (rsp_pop_s),
    .count     (fifo_count_s),
    .head      (rsp_rdata)
  );

  assign rsp_valid = (fifo_count_s != {CW{1'b0}});
  assign idle      = (fifo_count_s == {CW{1'b0}}) && !read_pend_r;

endmodule
